// File: rtl/wb_select_stage.sv
// rtl/wb_select_stage.sv - MEM/WB pipeline register with writeback data selection and load lane extraction
module wb_select_stage #(
    parameter int NBITS       = 32,
    parameter int NREG_ADDR   = 5,
    parameter int LINK_OFFSET = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [1:0]           i_wb_sel,
    input  logic [1:0]           i_load_size,
    input  logic                 i_load_unsigned,
    input  logic [1:0]           i_addr_lo,
    input  logic [NBITS-1:0]     i_mem_data,
    input  logic [NBITS-1:0]     i_alu_result,
    input  logic [NBITS-1:0]     i_pc,
    input  logic [15:0]          i_imm16,
    input  logic                 i_reg_write,
    input  logic [NREG_ADDR-1:0] i_rd,
    output logic [NBITS-1:0]     o_wb_data,
    output logic [NREG_ADDR-1:0] o_wb_addr,
    output logic                 o_wb_en,
    output logic                 o_valid,
    output logic                 o_misalign
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [NBITS-1:0] load_val;
    logic [NBITS-1:0] lui_val;
    logic [NBITS-1:0] next_data;
    logic             misalign;
    logic             next_en;

    always_comb begin
        case (i_addr_lo)
            2'd0:    byte_lane = i_mem_data[7:0];
            2'd1:    byte_lane = i_mem_data[15:8];
            2'd2:    byte_lane = i_mem_data[23:16];
            default: byte_lane = i_mem_data[31:24];
        endcase
        half_lane = i_addr_lo[1] ? i_mem_data[31:16] : i_mem_data[15:0];
    end

    // Fill the whole word with the extension bit, then overlay the lane.
    always_comb begin
        load_val = '0;
        case (i_load_size)
            SIZE_BYTE: begin
                load_val       = {NBITS{~i_load_unsigned & byte_lane[7]}};
                load_val[7:0]  = byte_lane;
            end
            SIZE_HALF: begin
                load_val       = {NBITS{~i_load_unsigned & half_lane[15]}};
                load_val[15:0] = half_lane;
            end
            default: begin
                load_val        = {NBITS{~i_load_unsigned & i_mem_data[31]}};
                load_val[31:0]  = i_mem_data[31:0];
            end
        endcase
    end

    always_comb begin
        lui_val        = '0;
        lui_val[31:16] = i_imm16;
        case (i_wb_sel)
            SEL_ALU:  next_data = i_alu_result;
            SEL_MEM:  next_data = load_val;
            SEL_LINK: next_data = i_pc + NBITS'(LINK_OFFSET);
            default:  next_data = lui_val;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        if (i_wb_sel == SEL_MEM) begin
            if (i_load_size == SIZE_HALF)
                misalign = i_addr_lo[0];
            else if (i_load_size != SIZE_BYTE)
                misalign = (i_addr_lo != 2'b00);
        end
        next_en = i_valid & i_reg_write & (i_rd != '0) & ~misalign;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_data  <= '0;
            o_wb_addr  <= '0;
            o_wb_en    <= 1'b0;
            o_valid    <= 1'b0;
            o_misalign <= 1'b0;
        end else if (i_flush) begin
            // Data and address deliberately hold; only the qualifiers drop.
            o_wb_en    <= 1'b0;
            o_valid    <= 1'b0;
            o_misalign <= 1'b0;
        end else if (!i_stall) begin
            o_wb_data  <= next_data;
            o_wb_addr  <= i_rd;
            o_wb_en    <= next_en;
            o_valid    <= i_valid;
            o_misalign <= i_valid & misalign;
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// tb/tb_wb_select_stage.sv - randomized scoreboard bench for wb_select_stage
module tb_wb_select_stage;

    logic        clk;
    logic        rst_n;
    logic        valid, stall, flush;
    logic [1:0]  wb_sel, load_size, addr_lo;
    logic        load_unsigned;
    logic [31:0] mem_data, alu_result, pc;
    logic [15:0] imm16;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_en, o_valid, misalign;

    wb_select_stage #(.NBITS(32), .NREG_ADDR(5), .LINK_OFFSET(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_wb_sel(wb_sel), .i_load_size(load_size), .i_load_unsigned(load_unsigned),
        .i_addr_lo(addr_lo), .i_mem_data(mem_data), .i_alu_result(alu_result), .i_pc(pc),
        .i_imm16(imm16), .i_reg_write(reg_write), .i_rd(rd),
        .o_wb_data(wb_data), .o_wb_addr(wb_addr), .o_wb_en(wb_en), .o_valid(o_valid),
        .o_misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [4:0]  addr;
        logic        en;
        logic        vld;
        logic        mis;
        logic        has_const;
        logic [31:0] cdata;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] m_data;
    logic [4:0]  m_addr;
    logic        m_en, m_vld, m_mis;

    function automatic logic [31:0] model_value(input logic [1:0] sel, input logic [1:0] size,
                                                input logic uns, input logic [1:0] alo,
                                                input logic [31:0] mem, input logic [31:0] alu,
                                                input logic [31:0] p, input logic [15:0] imm);
        logic [31:0] v;
        case (sel)
            2'd0: v = alu;
            2'd2: v = p + 32'd8;
            2'd3: v = {16'h0, imm} << 16;
            default: begin
                if (size == 2'd0) begin
                    v = (mem >> (8 * alo)) & 32'hFF;
                    if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
                end else if (size == 2'd1) begin
                    v = (mem >> (alo >= 2'd2 ? 16 : 0)) & 32'hFFFF;
                    if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
                end else begin
                    v = mem;
                end
            end
        endcase
        return v;
    endfunction

    function automatic logic model_misalign(input logic [1:0] sel, input logic [1:0] size,
                                            input logic [1:0] alo);
        if (sel != 2'd1) return 1'b0;
        if (size == 2'd1) return (alo % 2) == 1;
        if (size >= 2'd2) return alo != 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_data = '0; m_addr = '0; m_en = 0; m_vld = 0; m_mis = 0;
    endtask

    task automatic step(input string tag, input logic v, input logic st, input logic fl,
                        input logic [1:0] sel, input logic [1:0] size, input logic uns,
                        input logic [1:0] alo, input logic [31:0] mem, input logic [31:0] alu,
                        input logic [31:0] p, input logic [15:0] imm, input logic rw,
                        input logic [4:0] r, input logic hc, input logic [31:0] cd);
        exp_t e;
        logic mis;
        @(negedge clk);
        valid = v; stall = st; flush = fl; wb_sel = sel; load_size = size;
        load_unsigned = uns; addr_lo = alo; mem_data = mem; alu_result = alu; pc = p;
        imm16 = imm; reg_write = rw; rd = r;
        if (fl) begin
            m_en = 0; m_vld = 0; m_mis = 0;
        end else if (!st) begin
            mis    = model_misalign(sel, size, alo);
            m_data = model_value(sel, size, uns, alo, mem, alu, p, imm);
            m_addr = r;
            m_vld  = v;
            m_mis  = v && mis;
            m_en   = v && rw && (r != 0) && !mis;
        end
        e.tag = tag; e.data = m_data; e.addr = m_addr; e.en = m_en; e.vld = m_vld;
        e.mis = m_mis; e.has_const = hc; e.cdata = cd;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (wb_data !== e.data || wb_addr !== e.addr || wb_en !== e.en ||
                    o_valid !== e.vld || misalign !== e.mis) begin
                    n_err++;
                    $display("FAIL %s: got data=%h addr=%0d en=%b valid=%b mis=%b, want data=%h addr=%0d en=%b valid=%b mis=%b",
                             e.tag, wb_data, wb_addr, wb_en, o_valid, misalign,
                             e.data, e.addr, e.en, e.vld, e.mis);
                end
                if (e.has_const) begin
                    n_vec++;
                    if (wb_data !== e.cdata) begin
                        n_err++;
                        $display("FAIL %s_const: got data=%h, want %h", e.tag, wb_data, e.cdata);
                    end
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        n_vec++;
        if (wb_data !== 32'h0 || wb_addr !== 5'h0 || wb_en !== 1'b0 ||
            o_valid !== 1'b0 || misalign !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got data=%h addr=%0d en=%b valid=%b mis=%b, want all zero",
                     tag, wb_data, wb_addr, wb_en, o_valid, misalign);
        end
    endtask

    initial begin : stimulus
        logic [1:0] rs;
        rst_n = 0; valid = 0; stall = 1; flush = 0; wb_sel = 0; load_size = 0;
        load_unsigned = 0; addr_lo = 0; mem_data = 0; alu_result = 0; pc = 0;
        imm16 = 0; reg_write = 0; rd = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("reset_init");
        @(negedge clk) rst_n = 1;

        step("alu_pre_reset", 1, 0, 0, 2'd0, 2'd2, 0, 2'd0, 0, 32'hCAFEF00D, 0, 0, 1, 5'd7, 1, 32'hCAFEF00D);
        @(posedge clk);
        #3;
        stall = 1;
        rst_n = 0;
        #1 check_zero("reset_async");
        model_reset();
        @(negedge clk) rst_n = 1;

        step("lb_a3",  1, 0, 0, 2'd1, 2'd0, 0, 2'd3, 32'h80FF7F01, 0, 0, 0, 1, 5'd2, 1, 32'hFFFFFF80);
        step("lb_a1",  1, 0, 0, 2'd1, 2'd0, 0, 2'd1, 32'h80FF7F01, 0, 0, 0, 1, 5'd2, 1, 32'h0000007F);
        step("lbu_a2", 1, 0, 0, 2'd1, 2'd0, 1, 2'd2, 32'h80FF7F01, 0, 0, 0, 1, 5'd2, 1, 32'h000000FF);
        step("lh_a2",  1, 0, 0, 2'd1, 2'd1, 0, 2'd2, 32'h80FF7F01, 0, 0, 0, 1, 5'd4, 1, 32'hFFFF80FF);
        step("lui",    1, 0, 0, 2'd3, 2'd0, 0, 2'd0, 0, 0, 0, 16'h1234, 1, 5'd9, 1, 32'h12340000);
        step("link",   1, 0, 0, 2'd2, 2'd0, 0, 2'd0, 0, 0, 32'h00400010, 0, 1, 5'd31, 1, 32'h00400018);
        step("lh_mis", 1, 0, 0, 2'd1, 2'd1, 0, 2'd1, 32'h80FF7F01, 0, 0, 0, 1, 5'd5, 0, 0);
        step("clean",  1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 32'h11112222, 0, 0, 1, 5'd5, 1, 32'h11112222);
        step("lw_mis", 1, 0, 0, 2'd1, 2'd2, 0, 2'd2, 32'h01234567, 0, 0, 0, 1, 5'd6, 0, 0);
        step("alu_rd3", 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 32'hDEADBEEF, 0, 0, 1, 5'd3, 1, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++)
            step("stall_hold", $urandom_range(0, 1), 1, 0, 2'($urandom), 2'($urandom), 1'($urandom),
                 2'($urandom), $urandom, $urandom, $urandom, 16'($urandom), 1, 5'($urandom),
                 1, 32'hDEADBEEF);
        step("stall_flush", 1, 1, 1, 2'd0, 2'd0, 0, 2'd0, 0, 32'h55555555, 0, 0, 1, 5'd8, 1, 32'hDEADBEEF);
        step("rd_zero", 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 32'h0BADF00D, 0, 0, 1, 5'd0, 0, 0);
        step("invalid", 0, 0, 0, 2'd1, 2'd1, 0, 2'd1, 32'h8000FFFF, 0, 0, 0, 1, 5'd12, 0, 0);

        for (int i = 0; i < 400; i++) begin
            rs = 2'($urandom);
            step("random", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0), 2'($urandom), 2'($urandom), 1'($urandom),
                 2'($urandom), $urandom, $urandom, $urandom, 16'($urandom), 1'($urandom),
                 (rs == 0) ? 5'd0 : 5'($urandom), 0, 0);
        end

        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
